// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with a rotating priority pointer and a
// per-grant hold limit that force-releases an owner after MAX_HOLD cycles.
module rr_arbiter_8 #(
    parameter int MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    state_t     state;
    logic [2:0] ptr;
    logic [7:0] hold_cnt;
    logic [2:0] winner;
    logic       owner_req;
    logic       at_limit;
    logic       release_now;

    // Scan from the farthest offset down so the lowest offset from ptr wins.
    always_comb begin
        winner = '0;
        for (int i = 7; i >= 0; i--) begin
            if (req[ptr + 3'(i)]) begin
                winner = ptr + 3'(i);
            end
        end
    end

    assign owner_req   = req[grant_idx];
    assign at_limit    = (hold_cnt == HOLD_LIMIT);
    assign release_now = done | ~owner_req | at_limit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
            ptr       <= '0;
            hold_cnt  <= '0;
        end else if (state == IDLE) begin
            timeout <= 1'b0;
            if (|req) begin
                state     <= HOLD;
                busy      <= 1'b1;
                grant_idx <= winner;
                grant     <= 8'b1 << winner;
                hold_cnt  <= 8'd1;
            end else begin
                busy  <= 1'b0;
                grant <= '0;
            end
        end else begin
            if (release_now) begin
                state   <= IDLE;
                busy    <= 1'b0;
                grant   <= '0;
                ptr     <= grant_idx + 3'd1;
                // Only a pure hold-limit expiry counts as a timeout.
                timeout <= at_limit & ~done & owner_req;
            end else begin
                hold_cnt <= hold_cnt + 8'd1;
                timeout  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: directed scenarios plus randomized traffic checked
// against a behavioural arbitration model.
module tb_rr_arbiter_8;

    localparam int MAXH = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       busy;
    logic       timeout;

    int n_chk  = 0;
    int n_fail = 0;
    bit inv_on = 1'b0;

    // Reference model state
    bit m_busy;
    int m_owner;
    int m_next;
    int m_held;
    bit m_timeout;

    rr_arbiter_8 #(.MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .grant     (grant),
        .grant_idx (grant_idx),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Invariants checked on the falling edge of every cycle after reset.
    always @(negedge clk) begin
        if (inv_on) begin
            n_chk++;
            assert ($countones(grant) <= 1) else begin
                n_fail++;
                $error("FAIL onehot: observed %b expected at most one bit", grant);
            end
            n_chk++;
            assert (grant === (busy ? (8'b1 << grant_idx) : 8'h00)) else begin
                n_fail++;
                $error("FAIL decode: observed grant %b idx %0d busy %b", grant, grant_idx, busy);
            end
        end
    end

    function automatic void model_step(input bit r, input logic [7:0] rq, input bit d);
        if (r) begin
            m_busy = 0; m_owner = 0; m_next = 0; m_held = 0; m_timeout = 0;
        end else if (!m_busy) begin
            m_timeout = 0;
            if (rq != 0) begin
                for (int k = 7; k >= 0; k--)
                    if (rq[(m_next + k) % 8]) m_owner = (m_next + k) % 8;
                m_busy = 1;
                m_held = 1;
            end
        end else begin
            bit dropped, expired;
            dropped = !rq[m_owner];
            expired = (m_held >= MAXH);
            if (d || dropped || expired) begin
                m_busy    = 0;
                m_next    = (m_owner + 1) % 8;
                m_timeout = expired && !d && !dropped;
            end else begin
                m_held++;
                m_timeout = 0;
            end
        end
    endfunction

    // Apply inputs for one clock edge, advance the model, then compare.
    task automatic cyc(input bit r, input logic [7:0] rq, input bit d);
        rst = r; req = rq; done = d;
        @(posedge clk);
        model_step(r, rq, d);
        #1;
        chk("model_busy", {7'd0, busy}, {7'd0, m_busy});
        chk("model_idx", {5'd0, grant_idx}, 8'(m_owner));
        chk("model_grant", grant, m_busy ? (8'b1 << m_owner) : 8'h00);
        chk("model_timeout", {7'd0, timeout}, {7'd0, m_timeout});
    endtask

    initial begin
        $monitor("t=%0t rst=%b req=%b done=%b grant=%b idx=%0d busy=%b timeout=%b",
                 $time, rst, req, done, grant, grant_idx, busy, timeout);
        rst = 1'b1; req = '0; done = 1'b0;

        // Reset state
        cyc(1, 8'h00, 0);
        inv_on = 1'b1;
        chk("rst_grant", grant, 8'h00);
        chk("rst_idx", {5'd0, grant_idx}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_timeout", {7'd0, timeout}, 8'd0);

        // Single requester, released by done
        cyc(0, 8'h01, 0);
        chk("s_grant", grant, 8'h01);
        chk("s_busy", {7'd0, busy}, 8'd1);
        cyc(0, 8'h01, 1);
        chk("s_rel_grant", grant, 8'h00);
        chk("s_rel_busy", {7'd0, busy}, 8'd0);
        cyc(0, 8'h00, 0);

        // Full rotation with done every hold cycle
        cyc(1, 8'h00, 0);
        for (int g = 0; g < 9; g++) begin
            cyc(0, 8'hFF, 0);
            chk("rot_idx", {5'd0, grant_idx}, 8'(g % 8));
            chk("rot_busy", {7'd0, busy}, 8'd1);
            cyc(0, 8'hFF, 1);
            chk("rot_gap", {7'd0, busy}, 8'd0);
        end

        // Hold limit expiry
        cyc(1, 8'h00, 0);
        for (int c = 0; c < MAXH; c++) begin
            cyc(0, 8'h10, 0);
            chk("hold_grant", grant, 8'h10);
            chk("hold_to", {7'd0, timeout}, 8'd0);
        end
        cyc(0, 8'h10, 0);
        chk("exp_busy", {7'd0, busy}, 8'd0);
        chk("exp_timeout", {7'd0, timeout}, 8'd1);
        cyc(0, 8'h10, 0);
        chk("regrant_idx", {5'd0, grant_idx}, 8'd4);
        chk("regrant_to", {7'd0, timeout}, 8'd0);

        // Owner drops its request; pointer moves past it
        cyc(1, 8'h00, 0);
        cyc(0, 8'h04, 0);
        chk("drop_owner", {5'd0, grant_idx}, 8'd2);
        cyc(0, 8'h80, 0);
        chk("drop_busy", {7'd0, busy}, 8'd0);
        chk("drop_to", {7'd0, timeout}, 8'd0);
        cyc(0, 8'h84, 0);
        chk("drop_next", {5'd0, grant_idx}, 8'd7);

        // Reset in the middle of a hold
        cyc(1, 8'h00, 0);
        cyc(0, 8'h20, 0);
        chk("mid_owner", {5'd0, grant_idx}, 8'd5);
        cyc(1, 8'h21, 0);
        chk("mid_grant", grant, 8'h00);
        chk("mid_idx", {5'd0, grant_idx}, 8'd0);
        chk("mid_busy", {7'd0, busy}, 8'd0);
        cyc(0, 8'h21, 0);
        chk("mid_next", {5'd0, grant_idx}, 8'd0);

        // Randomized traffic against the model
        begin
            logic [7:0] rq;
            rq = 8'($urandom);
            for (int n = 0; n < 800; n++) begin
                if ($urandom_range(5) == 0) rq = 8'($urandom);
                cyc(($urandom_range(63) == 0), rq, ($urandom_range(11) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_8.md
RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 15, meaning the maximum number of consecutive cycles one requester may hold the grant (legal range 1..255).
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req  input  8  request lines, bit i = requester i, level-sensitive.
REQ-005 done  input  1  the current owner releases the grant, sampled only while busy=1.
REQ-006 grant  output  8  one-hot grant, the 3-to-8 decode of grant_idx while busy=1, otherwise all zeros.
REQ-007 grant_idx  output  3  index of the current or last owner.
REQ-008 busy  output  1  high while a grant is held.
REQ-009 timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE and HOLD.
REQ-011 The block SHALL keep a 3-bit priority pointer ptr; the search order SHALL be ptr, ptr+1, ..., ptr+7, with indices wrapping mod 8.
REQ-012 In IDLE with req!=0, the block SHALL select the first asserted req in search order and register it: next cycle busy=1, grant_idx=winner, grant=1<<winner, and the FSM SHALL be in HOLD (one-cycle grant latency).
REQ-013 In IDLE with req=0, the block SHALL leave all outputs and ptr unchanged, except grant=0 and busy=0.
REQ-014 The block SHALL keep an 8-bit hold counter; it SHALL load 1 on entry to HOLD and increment each cycle in HOLD.
REQ-015 In HOLD, the grant SHALL be released when any one of these holds: done=1, req[grant_idx]=0, or hold counter = MAX_HOLD.
REQ-016 Release SHALL take effect on the next cycle: FSM=IDLE, busy=0, grant=0, grant_idx retained, ptr=grant_idx+1 mod 8.
REQ-017 timeout SHALL pulse for exactly that same cycle only when the release cause is the counter alone, i.e. done=1 or req drop in the same cycle suppresses timeout.
REQ-018 After every grant, the block SHALL return to IDLE for at least one cycle; back-to-back grants SHALL be separated by exactly one idle cycle when requests remain.
REQ-019 Requests that assert or deassert for non-owners during HOLD SHALL have no effect until the next IDLE arbitration.
REQ-020 With MAX_HOLD=1, every grant SHALL last exactly one cycle and assert timeout unless done or req drop coincides.
REQ-021 grant SHALL never have more than one bit set in any cycle.
REQ-022 Fairness: with all 8 requests held continuously, each index SHALL be granted once in every 8 consecutive grants.

Reset
REQ-023 With rst=1 at a clock edge, the block SHALL set FSM=IDLE, grant=0, grant_idx=0, busy=0, timeout=0, ptr=0, hold counter=0.
REQ-024 rst SHALL take priority over every other input, including mid-HOLD; the next arbitration after reset SHALL start searching from index 0.

Verification
REQ-025 Reset, then req=8'b0000_0001 -> grant=0000_0001, grant_idx=0, busy=1 one cycle later; done=1 for one cycle -> next cycle grant=0, busy=0.
REQ-026 req=8'hFF held, done pulsed each HOLD cycle -> grant_idx sequence 0,1,2,3,4,5,6,7,0 with one idle cycle between grants.
REQ-027 MAX_HOLD=15, req=8'b0001_0000 held, done=0 -> grant=0001_0000 for exactly 15 cycles, then timeout=1 for one cycle with busy=0, then a re-grant to index 4 one cycle later.
REQ-028 Owner 2 in HOLD, req changes 8'b0000_0100 -> 8'b1000_0000 -> release next cycle with timeout=0 and ptr=3; the next grant goes to index 7.
REQ-029 rst=1 asserted mid-HOLD with owner 5 and req=8'b0010_0001 -> next cycle all outputs are 0; the following grant goes to index 0, not 5.
REQ-030 The bench SHALL check throughout every run that the one-hot property holds and that grant = decode(grant_idx) whenever busy=1, and log with $monitor.
